// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small write FIFO and a pollable status word.
// Sits on the core IO bus as a responder; bytes written to UART_DATA are serialised on TXD.
module io_uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 40_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IO_mem_addr,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [31:0] IO_mem_rdata,
    output logic        TXD
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DEPTH_CNT = 4'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("io_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("io_uart_tx: FIFO_DEPTH must be a power of two in 2..8");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic             sel_io, sel_data, sel_stat;
    logic             push_req, push, pop, full, empty;
    logic             ovf_q, ovf_d;
    logic [3:0]       count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]       mem [FIFO_DEPTH];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             baud_done;

    logic unused_bits;
    assign unused_bits = ^{IO_mem_addr[31:23], IO_mem_addr[21:5], IO_mem_addr[2:0],
                           IO_mem_wdata[31:8]};

    // Word address bit 1 is byte address bit 3, word bit 2 is byte bit 4.
    assign sel_io   = IO_mem_addr[22];
    assign sel_data = sel_io & IO_mem_addr[3];
    assign sel_stat = sel_io & IO_mem_addr[4];

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == 4'd0);
    assign push_req = IO_mem_wr & sel_data;
    assign push     = push_req & ~full;

    assign count_d = count_q + 4'(push) - 4'(pop);

    always_comb begin
        ovf_d = ovf_q;
        if (IO_mem_wr && sel_stat && IO_mem_wdata[3]) begin
            ovf_d = 1'b0;
        end
        if (push_req && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= IO_mem_wdata[7:0];
        end
    end

    assign baud_done = (baud_q == BAUD_LAST);

    // TXD is computed one cycle ahead so the line comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    txd_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = StStart;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign TXD = txd_q;

    always_comb begin
        IO_mem_rdata = 32'd0;
        if (sel_data || sel_stat) begin
            IO_mem_rdata = {20'd0, count_q, 4'd0, ovf_q, (state_q != StIdle), empty, full};
        end
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter that sits on the core's IO bus as a responder. It sits opposite the IO bus initiator (IO_mem_addr / IO_mem_wdata / IO_mem_wr / IO_mem_rdata). Bytes written by firmware go into a small FIFO and are serialised 8N1 on TXD. A combinational status word is returned on IO_mem_rdata for polling.

## Interface
- CLK_FREQ_HZ, default 40_000_000: core clock frequency.
- BAUD, default 115_200: line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD, integer-truncated; must be ≥ 2 (elaboration error otherwise).
- FIFO_DEPTH, default 8: transmit FIFO entries. Power of two, 2..8.
- clk  in  1  core clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- IO_mem_addr  in  32  IO byte address from the core.
- IO_mem_wdata  in  32  IO write data.
- IO_mem_wr  in  1  IO write strobe; single-cycle; the write happens on the edge that samples it.
- IO_mem_rdata  out  32  read data; combinational from IO_mem_addr and current state.
- TXD  out  1  serial line, idle high.

## Operation
- Decode: IO space is IO_mem_addr[22]=1. The word-address is IO_mem_addr[15:2], one-hot decoded.
  - Word bit 1 selects UART_DATA (0x400008).
  - Word bit 2 selects UART_STAT (0x400010).
  - The two decodes are independent; an address with both bits set hits both registers.
- Write to UART_DATA:
  - If the FIFO is not full, IO_mem_wdata[7:0] is pushed.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - Full is evaluated before the edge: a push into a full FIFO is dropped even when a pop happens on the same edge.
- Write to UART_STAT: IO_mem_wdata[3]=1 clears `ovf` (write-1-to-clear). All other bits are ignored. If an overflow event and a clear land on the same edge, set wins.
- Read (either register selected and addr[22]=1): IO_mem_rdata = {20'b0, count[3:0], 4'b0, ovf, tx_active, empty, full}.
  - Any other address returns 0.
  - Reads have no side effects.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits that wrap modulo depth.
  - count has 4 bits, range 0..FIFO_DEPTH.
  - Simultaneous push and pop (FIFO not full) leaves count unchanged.
- Transmit FSM, with bit counter 0..7 and baud counter 0..CLKS_PER_BIT-1:
  - IDLE: TXD=1, tx_active=0. If the FIFO is not empty, pop into the shift register and go to START.
  - START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TXD=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, 8 bits, then go to STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is not empty, pop and go directly to START; otherwise go to IDLE.
- TXD is driven from a register, so it has no glitches.

## Timing
- Reset values:
  - TXD=1, state IDLE, FIFO empty (count=0), ovf=0, tx_active=0.
  - IO_mem_rdata follows from these: UART_STAT reads 0x00000002.
- Reset mid-frame aborts the frame. TXD=1 from the next edge, and FIFO contents are discarded.
- Write-to-line latency:
  - Applies with the FIFO empty and the FSM in IDLE.
  - A write sampled at edge E0 makes the FIFO non-empty.
  - The pop happens at E1, and TXD=0 from E1.
  - The frame occupies 10·CLKS_PER_BIT cycles.
- Back-to-back frames have no idle gap: the next start bit begins exactly CLKS_PER_BIT cycles after the stop bit began.
- Status is combinational on address, so it is valid in the same cycle the core presents IO_mem_addr. It reflects register state as of the last edge.
- Flag definitions:
  - tx_active=1 in START, DATA and STOP.
  - empty = (count==0).
  - full = (count==FIFO_DEPTH).

## Test plan
All scenarios use CLK_FREQ_HZ=40_000_000, BAUD=10_000_000 (CLKS_PER_BIT=4) and FIFO_DEPTH=8.
- Single byte: write 0x55 to 0x400008 at E0 → TXD=0 from E1. The line then shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, for 40 cycles, then TXD=1 and UART_STAT=0x00000002.
- Back-to-back: write 0xA5, 0x0F, 0xFF on three consecutive cycles → 120 contiguous frame cycles with no idle cycle between frames, correct LSB-first bits, and empty=1 afterwards.
- Overflow: 10 consecutive writes 0x00..0x09 → bytes 0x00..0x08 are transmitted and 0x09 is dropped. After E9, UART_STAT=0x0000080D (count=8, ovf, tx_active, full).
- Overflow clear: write 0x8 to 0x400010 → ovf=0 next cycle while transmission continues. Writing 0x0 leaves ovf unchanged.
- Reset mid-frame: assert reset during bit 3 of 0x00 with 2 bytes queued → TXD=1 from the next edge, UART_STAT=0x00000002, and no further frames after reset is released.
- Decode: read 0x000010 (addr[22]=0) → 0. Read 0x400004 → 0. A write to 0x400004 pushes nothing (count stays 0).
